// File: rtl/shortfifo_arb_pkg.sv
// Shared constants and helpers for the round-robin write-arbitrated short FIFO.
package shortfifo_arb_pkg;

    localparam int unsigned STAT_W = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    // Saturating increment used by the per-requester grant counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == STAT_MAX) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/shortfifo_arb_rr_pick.sv
// Round-robin picker: first requester at or after ptr (mod nreq) wins.
module rr_pick #(
    parameter int unsigned nreq = 4,
    parameter int unsigned tw   = $clog2(nreq)
) (
    input  logic [nreq-1:0] req,
    input  logic [tw-1:0]   ptr,
    output logic [nreq-1:0] gnt,
    output logic [tw-1:0]   win
);

    logic          found;
    logic [tw-1:0] cand;

    // nreq is a power of two, so the tw-bit add wraps modulo nreq.
    always_comb begin
        gnt   = '0;
        win   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < int'(nreq); k++) begin
            cand = ptr + tw'(k);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                win       = cand;
            end
        end
    end

endmodule

// File: rtl/shortfifo_arb.sv
// Short show-ahead FIFO whose write port is shared round-robin among nreq
// requesters; each entry remembers its source, with saturating grant counters.
module shortfifo_arb
    import shortfifo_arb_pkg::*;
#(
    parameter int unsigned dw   = 8,
    parameter int unsigned aw   = 3,
    parameter int unsigned nreq = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [nreq-1:0]           req,
    input  logic [nreq*dw-1:0]        din,
    output logic [nreq-1:0]           gnt,
    output logic [dw-1:0]             dout,
    output logic [$clog2(nreq)-1:0]   dout_src,
    input  logic                      re,
    output logic                      empty,
    output logic                      full,
    output logic [aw:0]               count,
    input  logic                      stat_clr,
    output logic [nreq*STAT_W-1:0]    stat
);

    localparam int unsigned tw    = $clog2(nreq);
    localparam int unsigned DEPTH = 2**aw;
    localparam int unsigned EW    = tw + dw;

    logic [tw-1:0]     ptr_q, ptr_d;
    logic [aw-1:0]     wr_ptr_q, wr_ptr_d;
    logic [aw-1:0]     rd_ptr_q, rd_ptr_d;
    logic [aw:0]       count_q, count_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic [STAT_W-1:0] stat_q [nreq];
    logic [STAT_W-1:0] stat_d [nreq];
    logic [EW-1:0]     mem_q [DEPTH];

    logic [nreq-1:0]   pick_gnt;
    logic [tw-1:0]     win;
    logic [dw-1:0]     wdata;
    logic              push;
    logic              pop;

    rr_pick #(
        .nreq (nreq),
        .tw   (tw)
    ) u_rr_pick (
        .req  (req),
        .ptr  (ptr_q),
        .gnt  (pick_gnt),
        .win  (win)
    );

    // A full FIFO blocks grants even if a pop happens in the same cycle.
    assign gnt  = (full_q || !rst_n) ? '0 : pick_gnt;
    assign push = |gnt;
    assign pop  = re && !empty_q;

    always_comb begin
        wdata = '0;
        for (int i = 0; i < int'(nreq); i++) begin
            if (win == tw'(i)) begin
                wdata = din[i*dw +: dw];
            end
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stat_d   = stat_q;
        if (push) begin
            ptr_d    = win + tw'(1);
            wr_ptr_d = wr_ptr_q + aw'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + aw'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (aw+1)'(1);
            2'b01:   count_d = count_q - (aw+1)'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == (aw+1)'(DEPTH));
        // Clear takes priority over a same-cycle increment.
        for (int i = 0; i < int'(nreq); i++) begin
            if (stat_clr) begin
                stat_d[i] = '0;
            end else if (gnt[i]) begin
                stat_d[i] = sat_inc(stat_q[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            for (int i = 0; i < int'(nreq); i++) begin
                stat_q[i] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            stat_q   <= stat_d;
        end
    end

    // Storage is not reset; contents are meaningless while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {win, wdata};
        end
    end

    assign {dout_src, dout} = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = empty_q;
    assign full  = full_q;

    always_comb begin
        stat = '0;
        for (int i = 0; i < int'(nreq); i++) begin
            stat[i*STAT_W +: STAT_W] = stat_q[i];
        end
    end

endmodule

// File: tb/tb_shortfifo_arb.sv
// Directed and model-checked bench for shortfifo_arb (dw=8, aw=3, nreq=4).
module tb_shortfifo_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic [7:0]  dout;
    logic [1:0]  dout_src;
    logic        re;
    logic        empty;
    logic        full;
    logic [3:0]  count;
    logic        stat_clr;
    logic [63:0] stat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shortfifo_arb #(
        .dw   (8),
        .aw   (3),
        .nreq (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .din      (din),
        .gnt      (gnt),
        .dout     (dout),
        .dout_src (dout_src),
        .re       (re),
        .empty    (empty),
        .full     (full),
        .count    (count),
        .stat_clr (stat_clr),
        .stat     (stat)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        rst_n = 1'b0; req = '0; re = 1'b0; stat_clr = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 4'b1111; re = 1'b1; stat_clr = 1'b0; din = 32'h33221100;
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (stat !== 64'd0) begin errors++; $display("FAIL reset_stat: got %h expected 0", stat); end
        rst_n = 1'b1; re = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt); end
    endtask

    task automatic test_fill();
        logic [3:0] e;
        for (int c = 0; c < 8; c++) begin
            e = 4'b0001 << (c % 4);
            checks++; if (gnt !== e) begin errors++; $display("FAIL fill_gnt%0d: got %b expected %b", c, gnt, e); end
            tick();
        end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", full); end
        checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count: got %0d expected 8", count); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL fill_gnt_full: got %b expected 0000", gnt); end
        checks++; if (dout !== 8'h00 || dout_src !== 2'd0) begin errors++; $display("FAIL fill_head: got %h/%0d expected 00/0", dout, dout_src); end
        tick();
        tick();
        checks++; if (count !== 4'd8 || gnt !== 4'b0000) begin errors++; $display("FAIL fill_hold: got count %0d gnt %b expected 8 0000", count, gnt); end
    endtask

    task automatic test_pop_full();
        req = 4'b0001; re = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL popfull_gnt: got %b expected 0000", gnt); end
        tick();
        re = 1'b0;
        checks++; if (count !== 4'd7 || full !== 1'b0) begin errors++; $display("FAIL popfull_count: got %0d/%b expected 7/0", count, full); end
        checks++; if (dout !== 8'h11 || dout_src !== 2'd1) begin errors++; $display("FAIL popfull_head: got %h/%0d expected 11/1", dout, dout_src); end
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL popfull_regnt: got %b expected 0001", gnt); end
        tick();
        req = 4'b0000;
        checks++; if (count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL popfull_refill: got %0d/%b expected 8/1", count, full); end
    endtask

    task automatic test_simul();
        logic [1:0] es;
        hard_reset();
        req = 4'b1111; din = 32'h33221100;
        tick(); tick(); tick();
        req = 4'b1000; re = 1'b1;
        #1;
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL simul_gnt: got %b expected 1000", gnt); end
        checks++; if (count !== 4'd3 || dout_src !== 2'd0) begin errors++; $display("FAIL simul_pre: got %0d/%0d expected 3/0", count, dout_src); end
        tick();
        req = 4'b0000;
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL simul_count: got %0d expected 3", count); end
        for (int j = 1; j <= 3; j++) begin
            es = 2'(j);
            checks++; if (dout_src !== es || dout !== 8'(j * 17)) begin errors++; $display("FAIL simul_order%0d: got %h/%0d expected %h/%0d", j, dout, dout_src, 8'(j * 17), es); end
            tick();
        end
        re = 1'b0;
        checks++; if (empty !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL simul_drain: got %b/%0d expected 1/0", empty, count); end
    endtask

    task automatic test_random();
        int q_src[$];
        int q_dat[$];
        int m_ptr;
        int k[4];
        int m_stat[4];
        int last[4];
        int w;
        int idx;
        int s;
        logic [3:0] r;
        logic [3:0] e;
        hard_reset();
        m_ptr = 0; r = '0;
        for (int i = 0; i < 4; i++) begin k[i] = 0; m_stat[i] = 0; last[i] = i * 64 - 1; end
        for (int cyc = 0; cyc < 1000; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!r[i] && $urandom_range(0, 1) == 1) r[i] = 1'b1;
                din[i*8 +: 8] = 8'(i * 64 + k[i]);
            end
            req = r;
            re = ($urandom_range(0, 2) == 0);
            #1;
            w = -1;
            if (q_src.size() < 8) begin
                for (int j = 0; j < 4; j++) begin
                    idx = (m_ptr + j) % 4;
                    if (w < 0 && r[idx]) w = idx;
                end
            end
            e = (w < 0) ? 4'b0000 : 4'(1 << w);
            checks++; if (gnt !== e) begin errors++; $display("FAIL rand_gnt c%0d: got %b expected %b", cyc, gnt, e); end
            checks++; if (count !== 4'(q_src.size())) begin errors++; $display("FAIL rand_count c%0d: got %0d expected %0d", cyc, count, q_src.size()); end
            checks++; if (empty !== (q_src.size() == 0) || full !== (q_src.size() == 8)) begin errors++; $display("FAIL rand_flags c%0d: got %b/%b size %0d", cyc, empty, full, q_src.size()); end
            if (q_src.size() > 0) begin
                checks++; if (dout_src !== 2'(q_src[0]) || dout !== 8'(q_dat[0])) begin errors++; $display("FAIL rand_head c%0d: got %h/%0d expected %h/%0d", cyc, dout, dout_src, 8'(q_dat[0]), q_src[0]); end
                if (re) begin
                    s = q_src[0];
                    checks++; if (dout !== 8'(last[s] + 1)) begin errors++; $display("FAIL rand_seq c%0d src%0d: got %h expected %h", cyc, s, dout, 8'(last[s] + 1)); end
                    last[s] = last[s] + 1;
                    void'(q_src.pop_front());
                    void'(q_dat.pop_front());
                end
            end
            if (w >= 0) begin
                q_src.push_back(w);
                q_dat.push_back(w * 64 + k[w]);
                k[w]++;
                m_stat[w]++;
                m_ptr = (w + 1) % 4;
                r[w] = 1'b0;
            end
            tick();
        end
        req = '0; re = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (stat[i*16 +: 16] !== 16'(m_stat[i])) begin errors++; $display("FAIL rand_stat%0d: got %0d expected %0d", i, stat[i*16 +: 16], m_stat[i]); end
        end
    endtask

    task automatic test_sat();
        hard_reset();
        req = 4'b0100; re = 1'b1; din = 32'h005A0000;
        repeat (65534) tick();
        checks++; if (stat[47:32] !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h expected fffe", stat[47:32]); end
        tick();
        checks++; if (stat[47:32] !== 16'hFFFF) begin errors++; $display("FAIL sat_hit: got %h expected ffff", stat[47:32]); end
        repeat (3) tick();
        checks++; if (stat[47:32] !== 16'hFFFF || gnt !== 4'b0100) begin errors++; $display("FAIL sat_hold: got %h gnt %b expected ffff 0100", stat[47:32], gnt); end
        stat_clr = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL sat_clr_gnt: got %b expected 0100", gnt); end
        tick();
        stat_clr = 1'b0;
        checks++; if (stat !== 64'd0) begin errors++; $display("FAIL sat_clr: got %h expected 0", stat); end
        tick();
        checks++; if (stat[47:32] !== 16'h0001) begin errors++; $display("FAIL sat_resume: got %h expected 0001", stat[47:32]); end
        req = '0; re = 1'b0;
    endtask

    task automatic test_async_reset();
        hard_reset();
        req = 4'b1111; din = 32'h33221100;
        repeat (5) tick();
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL arst_pre: got %0d expected 5", count); end
        req = 4'b1001;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || count !== 4'd0 || full !== 1'b0) begin errors++; $display("FAIL arst_state: got %b/%0d/%b expected 1/0/0", empty, count, full); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL arst_gnt: got %b expected 0000", gnt); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL arst_ptr: got %b expected 0001", gnt); end
        tick();
        req = '0;
        checks++; if (count !== 4'd1 || dout_src !== 2'd0 || dout !== 8'h00) begin errors++; $display("FAIL arst_first: got %0d/%0d/%h expected 1/0/00", count, dout_src, dout); end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; din = '0; re = 1'b0; stat_clr = 1'b0;
        test_reset();
        test_fill();
        test_pop_full();
        test_simul();
        test_random();
        test_sat();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
